// File: rtl/noc_pkg.sv
// Shared flit, direction and port encodings for the mesh router pipeline stages.
package noc_pkg;

    localparam logic [1:0] FLIT_HEAD   = 2'b10;
    localparam logic [1:0] FLIT_BODY   = 2'b00;
    localparam logic [1:0] FLIT_TAIL   = 2'b01;
    localparam logic [1:0] FLIT_SINGLE = 2'b11;

    localparam logic [3:0] DIR_N = 4'b0001;
    localparam logic [3:0] DIR_S = 4'b0010;
    localparam logic [3:0] DIR_W = 4'b0100;
    localparam logic [3:0] DIR_E = 4'b1000;
    localparam logic [3:0] DIR_L = 4'b0000;

    localparam logic [1:0] P_N = 2'd0;
    localparam logic [1:0] P_W = 2'd1;
    localparam logic [1:0] P_L = 2'd2;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } out_state_t;

    // Round-robin successor in N -> W -> L -> N order.
    function automatic logic [1:0] next_port(input logic [1:0] p);
        return (p == P_L) ? P_N : p + 2'd1;
    endfunction

    function automatic logic [1:0] oh_idx(input logic [2:0] oh);
        return oh[2] ? P_L : (oh[1] ? P_W : P_N);
    endfunction

endpackage

// File: rtl/sa_22_if.sv
// Flit handshake bundle between the RC stages, the allocator and the output links.
interface sa_22_if #(
    parameter int DATASIZE = 40
);
    logic [DATASIZE-1:0] N_data_in, W_data_in, L_data_in;
    logic [3:0]          N_dir_in, W_dir_in, L_dir_in;
    logic                N_valid_in, W_valid_in, L_valid_in;
    logic                N_ready_out, W_ready_out, L_ready_out;
    logic [DATASIZE-1:0] N_data_out, W_data_out, L_data_out;
    logic                N_valid_out, W_valid_out, L_valid_out;
    logic                N_ready_in, W_ready_in, L_ready_in;
    logic [2:0]          err_drop;

    modport slave (
        input  N_data_in, W_data_in, L_data_in,
        input  N_dir_in, W_dir_in, L_dir_in,
        input  N_valid_in, W_valid_in, L_valid_in,
        input  N_ready_in, W_ready_in, L_ready_in,
        output N_ready_out, W_ready_out, L_ready_out,
        output N_data_out, W_data_out, L_data_out,
        output N_valid_out, W_valid_out, L_valid_out,
        output err_drop
    );

    modport master (
        output N_data_in, W_data_in, L_data_in,
        output N_dir_in, W_dir_in, L_dir_in,
        output N_valid_in, W_valid_in, L_valid_in,
        output N_ready_in, W_ready_in, L_ready_in,
        input  N_ready_out, W_ready_out, L_ready_out,
        input  N_data_out, W_data_out, L_data_out,
        input  N_valid_out, W_valid_out, L_valid_out,
        input  err_drop
    );
endinterface

// File: rtl/rr_arb3.sv
// Three-way round-robin arbiter: first request at or after ptr wins, one-hot grant.
module rr_arb3
    import noc_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] ptr,
    output logic [2:0] gnt
);
    logic [1:0] idx;
    logic       found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = ptr;
        for (int k = 0; k < 3; k++) begin
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
            idx = next_port(idx);
        end
    end
endmodule

// File: rtl/sa_22.sv
// Switch allocator + crossbar for mesh corner (2,2): inputs N/W/L to outputs N/W/L, wormhole locked.
//  state     | meaning
//  ST_IDLE   | output free; round-robin among HEAD/SINGLE requesters
//  ST_LOCKED | output owned by one input until its TAIL is accepted
module sa_22
    import noc_pkg::*;
#(
    parameter int DATASIZE = 40,
    parameter int WIDTH    = 3
)(
    input  logic   sa_clk,
    input  logic   rst_n,
    sa_22_if.slave bus
);
    // WIDTH is carried only so this stage shares a parameter set with RC/FIFO.
    localparam int DIRB = (WIDTH > 0) ? 4 : 4;

    logic [DATASIZE-1:0] din [3];
    logic [DIRB-1:0]     dir [3];
    logic [2:0]          vin, rdy_in, rdy_out, can_acc, drop;

    logic [1:0] ftype [3];
    logic [1:0] tgt   [3];
    logic [2:0] is_hs;

    logic [2:0] req     [3];
    logic [2:0] arb_gnt [3];
    logic [2:0] gnt     [3];

    out_state_t st_q [3], st_d [3];
    logic [1:0] owner_q [3], owner_d [3];
    logic [1:0] ptr_q [3], ptr_d [3];
    logic [2:0] lock_v_q, lock_v_d;
    logic [1:0] lock_o_q [3], lock_o_d [3];

    logic [DATASIZE-1:0] dout_q [3];
    logic [2:0]          vout_q, err_q;

    assign din[P_N] = bus.N_data_in;
    assign din[P_W] = bus.W_data_in;
    assign din[P_L] = bus.L_data_in;
    assign dir[P_N] = bus.N_dir_in;
    assign dir[P_W] = bus.W_dir_in;
    assign dir[P_L] = bus.L_dir_in;
    assign vin      = {bus.L_valid_in, bus.W_valid_in, bus.N_valid_in};
    assign rdy_in   = {bus.L_ready_in, bus.W_ready_in, bus.N_ready_in};

    assign bus.N_ready_out = rdy_out[P_N];
    assign bus.W_ready_out = rdy_out[P_W];
    assign bus.L_ready_out = rdy_out[P_L];
    assign bus.N_data_out  = dout_q[P_N];
    assign bus.W_data_out  = dout_q[P_W];
    assign bus.L_data_out  = dout_q[P_L];
    assign bus.N_valid_out = vout_q[P_N];
    assign bus.W_valid_out = vout_q[P_W];
    assign bus.L_valid_out = vout_q[P_L];
    assign bus.err_drop    = err_q;

    always_comb begin
        drop  = '0;
        is_hs = '0;
        for (int i = 0; i < 3; i++) begin
            logic       legal;
            logic [1:0] dec;
            ftype[i] = din[i][DATASIZE-1:DATASIZE-2];
            is_hs[i] = (ftype[i] == FLIT_HEAD) || (ftype[i] == FLIT_SINGLE);
            legal    = 1'b1;
            case (dir[i])
                DIR_N:   dec = P_N;
                DIR_W:   dec = P_W;
                DIR_L:   dec = P_L;
                default: begin dec = P_N; legal = 1'b0; end
            endcase
            tgt[i]  = is_hs[i] ? dec : lock_o_q[i];
            drop[i] = vin[i] && ((is_hs[i] && !legal) ||
                                 (!is_hs[i] && !lock_v_q[i]) ||
                                 (ftype[i] == FLIT_HEAD && lock_v_q[i]));
        end
    end

    // Idle outputs take only new packets; locked outputs take only the owner's BODY/TAIL.
    always_comb begin
        for (int o = 0; o < 3; o++) begin
            can_acc[o] = !vout_q[o] || rdy_in[o];
            for (int i = 0; i < 3; i++) begin
                req[o][i] = vin[i] && !drop[i] && (tgt[i] == 2'(o)) &&
                            ((st_q[o] == ST_IDLE && is_hs[i]) ||
                             (st_q[o] == ST_LOCKED && !is_hs[i] && owner_q[o] == 2'(i)));
            end
        end
    end

    for (genvar g = 0; g < 3; g++) begin : g_arb
        rr_arb3 u_arb (
            .req (req[g]),
            .ptr (ptr_q[g]),
            .gnt (arb_gnt[g])
        );
    end

    always_comb begin
        for (int o = 0; o < 3; o++) begin
            gnt[o] = '0;
            if (can_acc[o])
                gnt[o] = (st_q[o] == ST_IDLE) ? arb_gnt[o] : req[o];
        end
        for (int i = 0; i < 3; i++)
            rdy_out[i] = vin[i] && (drop[i] || gnt[0][i] || gnt[1][i] || gnt[2][i]);
    end

    always_comb begin
        st_d     = st_q;
        owner_d  = owner_q;
        ptr_d    = ptr_q;
        lock_v_d = lock_v_q;
        lock_o_d = lock_o_q;
        for (int o = 0; o < 3; o++) begin
            logic [1:0] gi;
            gi = oh_idx(gnt[o]);
            if (|gnt[o]) begin
                if (st_q[o] == ST_IDLE) begin
                    if (ftype[gi] == FLIT_HEAD) begin
                        st_d[o]      = ST_LOCKED;
                        owner_d[o]   = gi;
                        lock_v_d[gi] = 1'b1;
                        lock_o_d[gi] = 2'(o);
                    end else begin
                        ptr_d[o] = next_port(gi);
                    end
                end else if (ftype[gi] == FLIT_TAIL) begin
                    st_d[o]      = ST_IDLE;
                    lock_v_d[gi] = 1'b0;
                    ptr_d[o]     = next_port(owner_q[o]);
                end
            end
        end
    end

    always_ff @(posedge sa_clk) begin
        if (!rst_n) begin
            lock_v_q <= '0;
            vout_q   <= '0;
            err_q    <= '0;
            for (int o = 0; o < 3; o++) begin
                st_q[o]     <= ST_IDLE;
                owner_q[o]  <= P_N;
                ptr_q[o]    <= P_N;
                lock_o_q[o] <= P_N;
                dout_q[o]   <= '0;
            end
        end else begin
            lock_v_q <= lock_v_d;
            err_q    <= drop;
            for (int o = 0; o < 3; o++) begin
                st_q[o]     <= st_d[o];
                owner_q[o]  <= owner_d[o];
                ptr_q[o]    <= ptr_d[o];
                lock_o_q[o] <= lock_o_d[o];
                if (|gnt[o]) begin
                    dout_q[o] <= din[oh_idx(gnt[o])];
                    vout_q[o] <= 1'b1;
                end else if (rdy_in[o]) begin
                    vout_q[o] <= 1'b0;
                end
            end
        end
    end
endmodule
